// File: rtl/seven_seg_pkg.sv
// Shared definitions for the four-digit seven-segment display controller:
// converter FSM states, active-low segment codes and the digit encoder.
package seven_seg_pkg;

   localparam int REFRESH_DIV_DEFAULT = 50000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } bcd_state_t;

   // Segment order is gfedcba, a 0 lights the segment.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      case (digit)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   // Double-dabble correction: any nibble of 5 or more gets 3 added before the shift.
   function automatic logic [19:0] dabble_adjust(input logic [19:0] bcd);
      logic [19:0] res;
      res = bcd;
      for (int i = 0; i < 5; i++) begin
         if (res[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble, one bit
// per clock). busy covers the 16 shift cycles plus the single DONE cycle.
module bin2bcd_seq
   import seven_seg_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        busy,
   output logic        done,
   output logic [19:0] bcd
);

   bcd_state_t  r_state;
   bcd_state_t  w_next;
   logic [3:0]  r_cnt;
   logic [35:0] r_sr;
   logic [19:0] w_adj;
   logic [35:0] w_shifted;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the always blocks execute in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: every output of this block gets a default first; otherwise a path
   // through the case that skips an assignment infers a latch.
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_SHIFT;
         ST_SHIFT: begin
            busy = 1'b1;
            if (r_cnt == 4'd15) w_next = ST_DONE;
         end
         ST_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   assign w_adj     = dabble_adjust(r_sr[35:16]);
   assign w_shifted = {w_adj, r_sr[15:0]} << 1;

   // Upper 20 bits accumulate BCD, lower 16 hold the binary still to shift in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
         if (start) begin
            r_sr  <= {20'd0, bin};
            r_cnt <= '0;
         end
      end else if (r_state == ST_SHIFT) begin
         r_sr  <= w_shifted;
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign bcd = r_sr[35:16];

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Four-digit multiplexed seven-segment display of a 16-bit value, with leading
// zero blanking and dashes when the sample does not fit in four digits.
module seven_seg_display_ctrl
   import seven_seg_pkg::*;
#(
   parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic        enable,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp,
   output logic        busy,
   output logic        ovf
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [DIV_W-1:0] r_div;
   logic             w_tick;
   logic [1:0]       r_scan;
   logic [1:0]       w_scan_next;
   logic [3:0][3:0]  r_dig;
   logic             r_ovf;
   logic [6:0]       r_seg;
   logic [3:0]       r_an;
   logic [6:0]       w_seg_next;
   logic [3:0]       w_an_next;
   logic [3:0]       w_lead_zero;
   logic             w_start;
   logic             w_busy;
   logic             w_done;
   logic [19:0]      w_bcd;

   assign w_tick      = (r_div == DIV_W'(REFRESH_DIV - 1));
   assign w_scan_next = r_scan + 2'd1;
   // A sample is taken only as the scan wraps to digit 0 and the converter is free.
   assign w_start     = w_tick && (r_scan == 2'd3) && enable && !w_busy;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (w_start),
      .bin   (value),
      .busy  (w_busy),
      .done  (w_done),
      .bcd   (w_bcd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      r_div <= '0;
      else if (w_tick) r_div <= '0;
      else             r_div <= r_div + DIV_W'(1);
   end

   assign w_lead_zero[3] = (r_dig[3] == 4'd0);
   assign w_lead_zero[2] = w_lead_zero[3] && (r_dig[2] == 4'd0);
   assign w_lead_zero[1] = w_lead_zero[2] && (r_dig[1] == 4'd0);
   assign w_lead_zero[0] = 1'b0;

   always_comb begin
      w_seg_next = SEG_BLANK;
      if (r_ovf)                         w_seg_next = SEG_DASH;
      else if (!w_lead_zero[w_scan_next]) w_seg_next = seg_encode(r_dig[w_scan_next]);
   end

   assign w_an_next = ~(4'b0001 << w_scan_next);

   // an/seg are registered for the index being advanced to, so they switch together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_scan <= '0;
         r_an   <= 4'b1111;
         r_seg  <= SEG_BLANK;
      end else if (w_tick) begin
         r_scan <= w_scan_next;
         r_an   <= w_an_next;
         r_seg  <= w_seg_next;
      end
   end

   // NOTE: the digit registers are a handful of flops feeding the display, so
   // they take the async reset; an interrupted conversion can never leak out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dig <= '0;
         r_ovf <= 1'b0;
      end else if (w_done) begin
         r_dig <= w_bcd[15:0];
         r_ovf <= |w_bcd[19:16];
      end
   end

   assign seg  = r_seg;
   assign an   = r_an;
   assign dp   = 1'b1;
   assign busy = w_busy;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed bench for seven_seg_display_ctrl with REFRESH_DIV=4: a vector table
// of values and expected scanned frames, then reset, busy and enable sequences.
module tb_seven_seg_display_ctrl;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

   typedef struct {
      logic [15:0] value;
      logic [27:0] exp_seg;   // {digit3, digit2, digit1, digit0}
      logic        exp_ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value;
   logic        enable;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        busy;
   logic        ovf;

   int n_vec = 0;
   int n_err = 0;

   vec_t vecs [8];

   seven_seg_display_ctrl #(.REFRESH_DIV(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .value  (value),
      .enable (enable),
      .seg    (seg),
      .an     (an),
      .dp     (dp),
      .busy   (busy),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_busy(input logic lvl, input string name);
      for (int k = 0; k < 80 && busy !== lvl; k++) @(negedge clk);
      check(name, 32'(busy), 32'(lvl));
   endtask

   task automatic measure_busy(output int len);
      len = 0;
      while (busy === 1'b1 && len < 100) begin
         len++;
         @(negedge clk);
      end
   endtask

   task automatic scan_frame(output logic [27:0] segs, output logic ok, output logic busy_seen);
      logic [3:0] seen;
      segs      = '1;
      ok        = 1'b1;
      seen      = '0;
      busy_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         busy_seen = busy_seen | busy;
         if (dp !== 1'b1) ok = 1'b0;
         case (an)
            4'b1110: begin segs[6:0]   = seg; seen[0] = 1'b1; end
            4'b1101: begin segs[13:7]  = seg; seen[1] = 1'b1; end
            4'b1011: begin segs[20:14] = seg; seen[2] = 1'b1; end
            4'b0111: begin segs[27:21] = seg; seen[3] = 1'b1; end
            4'b1111: ;
            default: ok = 1'b0;
         endcase
      end
      if (seen != 4'hF) ok = 1'b0;
   endtask

   task automatic apply_vector(input vec_t v, input string name);
      int          len;
      logic [27:0] segs;
      logic        ok;
      logic        bsy;
      wait_busy(1'b0, {name, "_idle"});
      value  = v.value;
      enable = 1'b1;
      wait_busy(1'b1, {name, "_start"});
      measure_busy(len);
      check({name, "_busy_len"}, len, 17);
      repeat (16) @(negedge clk);
      scan_frame(segs, ok, bsy);
      check({name, "_frame"}, {ok, segs}, {1'b1, v.exp_seg});
      check({name, "_ovf"}, 32'(ovf), 32'(v.exp_ovf));
   endtask

   // Expects to be entered at the negedge on which reset is released.
   task automatic post_release_checks(input string name);
      logic [27:0] segs;
      logic        ok;
      logic        bsy;
      repeat (3) @(negedge clk);
      check({name, "_pretick_an"}, 32'(an), 32'hF);
      @(negedge clk);
      check({name, "_tick1_an"}, 32'(an), 32'b1101);
      check({name, "_tick1_seg"}, 32'(seg), 32'(SB));
      scan_frame(segs, ok, bsy);
      check({name, "_frame"}, {ok, segs}, {1'b1, SB, SB, SB, S0});
      check({name, "_ovf"}, 32'(ovf), 32'd0);
      check({name, "_no_busy"}, 32'(bsy), 32'd0);
   endtask

   initial begin
      int          gap;
      int          len;
      logic [27:0] segs;
      logic        ok;
      logic        bsy;
      logic        any_busy;

      vecs[0] = '{16'd1234,  {S1, S2, S3, S4}, 1'b0};
      vecs[1] = '{16'd0,     {SB, SB, SB, S0}, 1'b0};
      vecs[2] = '{16'd9999,  {S9, S9, S9, S9}, 1'b0};
      vecs[3] = '{16'd10000, {SD, SD, SD, SD}, 1'b1};
      vecs[4] = '{16'd7,     {SB, SB, SB, S7}, 1'b0};
      vecs[5] = '{16'd305,   {SB, S3, S0, S5}, 1'b0};
      vecs[6] = '{16'd1000,  {S1, S0, S0, S0}, 1'b0};
      vecs[7] = '{16'd65535, {SD, SD, SD, SD}, 1'b1};

      reset  = 1'b1;
      enable = 1'b0;
      value  = '0;
      #3 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_an",   32'(an),   32'hF);
      check("rst_seg",  32'(seg),  32'(SB));
      check("rst_dp",   32'(dp),   32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf",  32'(ovf),  32'd0);
      reset = 1'b1;
      post_release_checks("por");

      for (int i = 0; i < 8; i++) apply_vector(vecs[i], $sformatf("vec%0d", i));

      // Reset five cycles into SHIFT while the dashed overflow display is up.
      wait_busy(1'b0, "mid_idle");
      value = 16'd1234;
      wait_busy(1'b1, "mid_start");
      repeat (5) @(negedge clk);
      reset  = 1'b0;
      enable = 1'b0;
      #1;
      check("mid_rst_an",   32'(an),   32'hF);
      check("mid_rst_seg",  32'(seg),  32'(SB));
      check("mid_rst_dp",   32'(dp),   32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ovf",  32'(ovf),  32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      post_release_checks("mid");

      // A frame wrap lands during busy; the next start must wait a full frame.
      value  = 16'd4321;
      enable = 1'b1;
      wait_busy(1'b1, "gap_start");
      measure_busy(len);
      check("gap_busy_len", len, 17);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (busy !== 1'b1 && gap < 100);
      check("gap_idle_cycles", gap, 15);
      scan_frame(segs, ok, bsy);
      check("gap_frame", {ok, segs}, {1'b1, S4, S3, S2, S1});

      // Freeze: enable low, value changes, display keeps the old number.
      apply_vector(vecs[0], "frz_pre");
      wait_busy(1'b0, "frz_idle");
      enable   = 1'b0;
      value    = 16'd42;
      any_busy = 1'b0;
      for (int f = 0; f < 3; f++) begin
         scan_frame(segs, ok, bsy);
         any_busy = any_busy | bsy;
         check($sformatf("frz_frame%0d", f), {ok, segs}, {1'b1, S1, S2, S3, S4});
      end
      check("frz_no_busy", 32'(any_busy), 32'd0);
      check("frz_ovf", 32'(ovf), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
